// File: rtl/signal_window_pkg.sv
// Shared grid dimensions, field widths and neighbour-index helpers for the
// 3x3 signal window extractor.
package signal_window_pkg;

    localparam int GRID_W      = 160;
    localparam int GRID_H      = 120;
    localparam int X_bits      = 8;
    localparam int Y_bits      = 7;
    localparam int SIGNAL_bits = 4;

    localparam int NBR_N  = 0;
    localparam int NBR_NE = 1;
    localparam int NBR_E  = 2;
    localparam int NBR_SE = 3;
    localparam int NBR_S  = 4;
    localparam int NBR_SW = 5;
    localparam int NBR_W  = 6;
    localparam int NBR_NW = 7;

    // Row offset of a neighbour relative to the centre (-1 = north).
    function automatic int nbr_drow(input int idx);
        case (idx)
            NBR_N, NBR_NE, NBR_NW: return -1;
            NBR_S, NBR_SE, NBR_SW: return 1;
            default:               return 0;
        endcase
    endfunction

    // Column offset of a neighbour relative to the centre (-1 = west).
    function automatic int nbr_dcol(input int idx);
        case (idx)
            NBR_NE, NBR_E, NBR_SE: return 1;
            NBR_NW, NBR_W, NBR_SW: return -1;
            default:               return 0;
        endcase
    endfunction

endpackage

// File: rtl/signal_window_line_buffer.sv
// One-row delay line: a DEPTH-entry ring sharing a single pointer for write
// and read; o_data is the entry written DEPTH shifts earlier.
module line_buffer #(
    parameter int DEPTH = 160,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_next;

    assign w_ptr_next = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_shift) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Registered read prefetches the slot the next shift will overwrite, so
    // the old contents are on o_data exactly when that shift happens.
    always_ff @(posedge clk) begin
        if (i_shift) begin
            r_mem[r_ptr] <= i_data;
            r_rd_data    <= r_mem[w_ptr_next];
        end
    end

    assign o_data = r_rd_data;

endmodule

// File: rtl/signal_window.sv
// Streaming 3x3 neighbourhood extractor over the raster-order environment
// stream, with zero padding at the grid edges.
module signal_window #(
    parameter int GRID_W      = signal_window_pkg::GRID_W,
    parameter int GRID_H      = signal_window_pkg::GRID_H,
    parameter int X_bits      = signal_window_pkg::X_bits,
    parameter int Y_bits      = signal_window_pkg::Y_bits,
    parameter int SIGNAL_bits = signal_window_pkg::SIGNAL_bits
) (
    input  logic                         newLocClock,
    input  logic                         RESET_SIM,
    input  logic                         start,
    input  logic                         stall,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIGNAL_bits-1:0]       in_signal,
    input  logic                         in_sugar,
    output logic                         out_valid,
    output logic [X_bits-1:0]            win_x,
    output logic [Y_bits-1:0]            win_y,
    output logic [SIGNAL_bits-1:0]       cur_signal,
    output logic                         cur_sugar,
    output logic [7:0][SIGNAL_bits-1:0]  surrounding_signals,
    output logic                         frame_done,
    output logic                         busy
);
    import signal_window_pkg::*;

    localparam int CELL_W = SIGNAL_bits + 1;
    localparam int CNT_W  = $clog2(GRID_W * GRID_H + 1);
    localparam logic [CNT_W-1:0]  PRIME_LAST = CNT_W'(GRID_W);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(GRID_W * GRID_H - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LEN  = CNT_W'(GRID_W + 1);
    localparam logic [X_bits-1:0] X_LAST     = X_bits'(GRID_W - 1);
    localparam logic [Y_bits-1:0] Y_LAST     = Y_bits'(GRID_H - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [X_bits-1:0]   r_nx;
    logic [Y_bits-1:0]   r_ny;
    logic [X_bits-1:0]   r_x;
    logic [Y_bits-1:0]   r_y;
    logic                r_out_valid;
    logic                r_frame_done;
    logic [CELL_W-1:0]   r_win [3][3];
    logic [CELL_W-1:0]   w_col_in [3];
    logic [CELL_W-1:0]   w_cell_in;
    logic [CELL_W-1:0]   w_lb0;
    logic [CELL_W-1:0]   w_lb1;
    logic                w_accept;
    logic                w_inject;
    logic                w_step;
    logic                w_emit;
    logic                w_done;
    logic                w_x_lo;
    logic                w_x_hi;
    logic                w_y_lo;
    logic                w_y_hi;
    logic                w_unused_sugar;

    assign w_accept  = in_valid && in_ready;
    assign w_inject  = (r_state == FLUSH) && !stall && (r_cnt < FLUSH_LEN);
    assign w_done    = (r_state == FLUSH) && !stall && (r_cnt == FLUSH_LEN);
    assign w_step    = w_accept || w_inject;
    assign w_emit    = (w_accept && (r_state == RUN)) || w_inject;
    assign w_cell_in = w_accept ? {in_sugar, in_signal} : '0;

    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_state <= IDLE;
        end else if (!stall) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start && !stall) w_state_next = PRIME;
            end
            PRIME: begin
                in_ready = !stall;
                if (in_valid && !stall && (r_cnt == PRIME_LAST)) w_state_next = RUN;
            end
            RUN: begin
                in_ready = !stall;
                if (in_valid && !stall && (r_cnt == FRAME_LAST)) w_state_next = FLUSH;
            end
            FLUSH: begin
                if (w_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // r_cnt is the raster index of the next input during PRIME/RUN, then the
    // number of zero cells injected during FLUSH.
    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_cnt <= '0;
        end else if (!stall) begin
            case (r_state)
                PRIME:   if (w_accept) r_cnt <= r_cnt + 1'b1;
                RUN:     if (w_accept) r_cnt <= (r_cnt == FRAME_LAST) ? '0 : r_cnt + 1'b1;
                FLUSH:   if (w_inject) r_cnt <= r_cnt + 1'b1;
                default: r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_nx         <= '0;
            r_ny         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (!stall) begin
            r_out_valid  <= w_emit;
            r_frame_done <= w_done;
            if (r_state == IDLE) begin
                r_nx <= '0;
                r_ny <= '0;
            end else if (w_emit) begin
                r_x <= r_nx;
                r_y <= r_ny;
                if (r_nx == X_LAST) begin
                    r_nx <= '0;
                    r_ny <= (r_ny == Y_LAST) ? '0 : r_ny + 1'b1;
                end else begin
                    r_nx <= r_nx + 1'b1;
                end
            end
        end
    end

    line_buffer #(.DEPTH(GRID_W), .WIDTH(CELL_W)) u_lb0 (
        .clk     (newLocClock),
        .rst     (RESET_SIM),
        .i_shift (w_step),
        .i_data  (w_cell_in),
        .o_data  (w_lb0)
    );

    line_buffer #(.DEPTH(GRID_W), .WIDTH(CELL_W)) u_lb1 (
        .clk     (newLocClock),
        .rst     (RESET_SIM),
        .i_shift (w_step),
        .i_data  (w_lb0),
        .o_data  (w_lb1)
    );

    // Right-hand column: two rows up, one row up, newest cell.
    assign w_col_in[0] = w_lb1;
    assign w_col_in[1] = w_lb0;
    assign w_col_in[2] = w_cell_in;

    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_step) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
                r_win[r][2] <= w_col_in[r];
            end
        end
    end

    assign w_x_lo = (r_x == '0);
    assign w_x_hi = (r_x == X_LAST);
    assign w_y_lo = (r_y == '0);
    assign w_y_hi = (r_y == Y_LAST);

    // Edge masking also hides the previous/next row's cells that sit in the
    // side columns when the centre is on the first or last column.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nbr
            localparam int DR = nbr_drow(gi);
            localparam int DC = nbr_dcol(gi);
            logic w_mask;
            assign w_mask = ((DR < 0) && w_y_lo) || ((DR > 0) && w_y_hi) ||
                            ((DC < 0) && w_x_lo) || ((DC > 0) && w_x_hi);
            assign surrounding_signals[gi] =
                w_mask ? '0 : r_win[DR+1][DC+1][SIGNAL_bits-1:0];
        end
    endgenerate

    always_comb begin
        w_unused_sugar = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_unused_sugar = w_unused_sugar ^ r_win[r][c][SIGNAL_bits];
            end
        end
    end

    assign out_valid  = r_out_valid && !stall;
    assign frame_done = r_frame_done && !stall;
    assign win_x      = r_x;
    assign win_y      = r_y;
    assign cur_signal = r_win[1][1][SIGNAL_bits-1:0];
    assign cur_sugar  = r_win[1][1][SIGNAL_bits];

endmodule

// File: tb/tb_signal_window.sv
// Directed bench for signal_window on a 4x3 grid; cell i carries signal i+1
// and sugar only at index 5.
module tb_signal_window;

    logic             newLocClock = 1'b0;
    logic             RESET_SIM   = 1'b1;
    logic             start       = 1'b0;
    logic             stall       = 1'b0;
    logic             in_valid    = 1'b0;
    logic             in_ready;
    logic [3:0]       in_signal   = '0;
    logic             in_sugar    = 1'b0;
    logic             out_valid;
    logic [7:0]       win_x;
    logic [6:0]       win_y;
    logic [3:0]       cur_signal;
    logic             cur_sugar;
    logic [7:0][3:0]  surrounding_signals;
    logic             frame_done;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  cx    [16];
    logic [6:0]  cy    [16];
    logic [3:0]  csig  [16];
    logic        csug  [16];
    logic [31:0] csurr [16];
    int cap_n, stall_viol, first_acc, done_cyc;
    logic busy_after;

    signal_window #(.GRID_W(4), .GRID_H(3)) dut (
        .newLocClock         (newLocClock),
        .RESET_SIM           (RESET_SIM),
        .start               (start),
        .stall               (stall),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_signal           (in_signal),
        .in_sugar            (in_sugar),
        .out_valid           (out_valid),
        .win_x               (win_x),
        .win_y               (win_y),
        .cur_signal          (cur_signal),
        .cur_sugar           (cur_sugar),
        .surrounding_signals (surrounding_signals),
        .frame_done          (frame_done),
        .busy                (busy)
    );

    always #5 newLocClock = ~newLocClock;

    // Reference grid: signal of cell (x,y), zero outside the 4x3 grid.
    function automatic logic [3:0] ms(input int x, input int y);
        if (x < 0 || x > 3 || y < 0 || y > 2) return 4'd0;
        return 4'(y * 4 + x + 1);
    endfunction

    function automatic logic [31:0] exp_surr(input int x, input int y);
        logic [7:0][3:0] s;
        s[0] = ms(x,     y - 1);
        s[1] = ms(x + 1, y - 1);
        s[2] = ms(x + 1, y);
        s[3] = ms(x + 1, y + 1);
        s[4] = ms(x,     y + 1);
        s[5] = ms(x - 1, y + 1);
        s[6] = ms(x - 1, y);
        s[7] = ms(x - 1, y - 1);
        return s;
    endfunction

    function automatic logic [51:0] exp_win(input int i);
        int x = i % 4;
        int y = i / 4;
        return {8'(x), 7'(y), ms(x, y), (x == 1 && y == 1), exp_surr(x, y)};
    endfunction

    // Runs one frame (or stops after stop_at accepts), capturing every window.
    task automatic drive_frame(input bit gaps, input bit poke, input int stop_at);
        int idx = 0;
        bit done = 1'b0;
        cap_n = 0; stall_viol = 0; first_acc = -1; done_cyc = -1; busy_after = 1'b0;
        @(posedge newLocClock); #1;
        start = 1'b1; stall = 1'b0; in_valid = 1'b0;
        @(posedge newLocClock); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (stop_at > 0 && idx >= stop_at) break;
            stall     = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
            in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_signal = (idx < 12) ? 4'(idx + 1) : 4'd15;
            in_sugar  = (idx == 5);
            start     = poke && idx >= 1 && cap_n < 10 && (cyc % 3 == 0);
            @(negedge newLocClock);
            if (cyc == 0) busy_after = busy;
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            if (out_valid) begin
                if (cap_n < 16) begin
                    cx[cap_n] = win_x; cy[cap_n] = win_y; csig[cap_n] = cur_signal;
                    csug[cap_n] = cur_sugar; csurr[cap_n] = surrounding_signals;
                end
                cap_n++;
            end
            if (stall && out_valid) stall_viol++;
            if (frame_done) begin
                done = 1'b1;
                done_cyc = cyc;
            end
            @(posedge newLocClock); #1;
        end
        start = 1'b0; in_valid = 1'b0; stall = 1'b0;
        if (stop_at == 0) begin
            n_cmp++;
            if (!done) begin
                n_fail++;
                $display("FAIL frame_timeout: frame_done not seen, windows=%0d accepts=%0d", cap_n, idx);
            end
        end
    endtask

    task automatic test_reset();
        RESET_SIM = 1'b1;
        repeat (2) @(posedge newLocClock);
        @(negedge newLocClock);
        n_cmp++;
        if ({in_ready, out_valid, frame_done, busy} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {in_ready, out_valid, frame_done, busy}); end
        n_cmp++;
        if ({win_x, win_y, cur_signal, cur_sugar} !== 20'h0)
            begin n_fail++; $display("FAIL reset_win: got x=%0d y=%0d sig=%0d sug=%0d want 0", win_x, win_y, cur_signal, cur_sugar); end
        n_cmp++;
        if (surrounding_signals !== 32'h0)
            begin n_fail++; $display("FAIL reset_surr: got %h want 0", surrounding_signals); end
        RESET_SIM = 1'b0;
        @(posedge newLocClock);
        @(negedge newLocClock);
        n_cmp++;
        if ({busy, in_ready, out_valid} !== 3'b000)
            begin n_fail++; $display("FAIL idle_after_reset: got %b want 000", {busy, in_ready, out_valid}); end
    endtask

    task automatic test_continuous();
        drive_frame(1'b0, 1'b0, 0);
        n_cmp++;
        if (cap_n != 12) begin n_fail++; $display("FAIL cont_count: got %0d want 12", cap_n); end
        n_cmp++;
        if (busy_after !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1", busy_after); end
        n_cmp++;
        if (done_cyc - first_acc != 18)
            begin n_fail++; $display("FAIL done_latency: got %0d want 18", done_cyc - first_acc); end
        for (int i = 0; i < 12; i++) begin
            if (i < cap_n) begin
                n_cmp++;
                if ({cx[i], cy[i], csig[i], csug[i], csurr[i]} !== exp_win(i)) begin
                    n_fail++;
                    $display("FAIL cont_win%0d: got %h want %h", i, {cx[i], cy[i], csig[i], csug[i], csurr[i]}, exp_win(i));
                end
            end
        end
    endtask

    // Uses the windows captured by test_continuous.
    task automatic test_centre_corner();
        logic [31:0] want_c, want_00, want_32;
        want_c  = {4'd1, 4'd5, 4'd9, 4'd10, 4'd11, 4'd7, 4'd3, 4'd2};
        want_00 = {4'd0, 4'd0, 4'd0, 4'd5, 4'd6, 4'd2, 4'd0, 4'd0};
        want_32 = {4'd7, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8};
        n_cmp++;
        if ({csig[5], csug[5]} !== {4'd6, 1'b1})
            begin n_fail++; $display("FAIL centre_val: got sig=%0d sug=%0d want sig=6 sug=1", csig[5], csug[5]); end
        n_cmp++;
        if (csurr[5] !== want_c) begin n_fail++; $display("FAIL centre_surr: got %h want %h", csurr[5], want_c); end
        n_cmp++;
        if (csurr[0] !== want_00) begin n_fail++; $display("FAIL corner00_surr: got %h want %h", csurr[0], want_00); end
        n_cmp++;
        if (csurr[11] !== want_32) begin n_fail++; $display("FAIL corner32_surr: got %h want %h", csurr[11], want_32); end
    endtask

    task automatic test_stall_gaps();
        drive_frame(1'b1, 1'b0, 0);
        n_cmp++;
        if (cap_n != 12) begin n_fail++; $display("FAIL stall_count: got %0d want 12", cap_n); end
        n_cmp++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL stall_valid: got %0d valid-while-stalled want 0", stall_viol); end
        for (int i = 0; i < 12; i++) begin
            if (i < cap_n) begin
                n_cmp++;
                if ({cx[i], cy[i], csig[i], csug[i], csurr[i]} !== exp_win(i)) begin
                    n_fail++;
                    $display("FAIL stall_win%0d: got %h want %h", i, {cx[i], cy[i], csig[i], csug[i], csurr[i]}, exp_win(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_frame(1'b0, 1'b0, 7);
        #2 RESET_SIM = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, frame_done, busy} !== 4'b0000)
            begin n_fail++; $display("FAIL midreset_ctrl: got %b want 0000", {in_ready, out_valid, frame_done, busy}); end
        n_cmp++;
        if ({win_x, win_y, cur_signal, cur_sugar, surrounding_signals} !== 52'h0)
            begin n_fail++; $display("FAIL midreset_win: got %h want 0", {win_x, win_y, cur_signal, cur_sugar, surrounding_signals}); end
        @(negedge newLocClock);
        RESET_SIM = 1'b0;
        drive_frame(1'b0, 1'b0, 0);
        n_cmp++;
        if (cap_n != 12) begin n_fail++; $display("FAIL rerun_count: got %0d want 12", cap_n); end
        n_cmp++;
        if (done_cyc - first_acc != 18)
            begin n_fail++; $display("FAIL rerun_latency: got %0d want 18", done_cyc - first_acc); end
        for (int i = 0; i < 12; i++) begin
            if (i < cap_n) begin
                n_cmp++;
                if ({cx[i], cy[i], csig[i], csug[i], csurr[i]} !== exp_win(i)) begin
                    n_fail++;
                    $display("FAIL rerun_win%0d: got %h want %h", i, {cx[i], cy[i], csig[i], csug[i], csurr[i]}, exp_win(i));
                end
            end
        end
    endtask

    task automatic test_busy_poke();
        drive_frame(1'b0, 1'b1, 0);
        n_cmp++;
        if (cap_n != 12) begin n_fail++; $display("FAIL poke_count: got %0d want 12", cap_n); end
        for (int i = 0; i < 12; i++) begin
            if (i < cap_n) begin
                n_cmp++;
                if ({cx[i], cy[i], csig[i], csug[i], csurr[i]} !== exp_win(i)) begin
                    n_fail++;
                    $display("FAIL poke_win%0d: got %h want %h", i, {cx[i], cy[i], csig[i], csug[i], csurr[i]}, exp_win(i));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge newLocClock);
            n_cmp++;
            if ({busy, out_valid} !== 2'b00)
                begin n_fail++; $display("FAIL poke_idle%0d: got busy=%b valid=%b want 0 0", k, busy, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_centre_corner();
        test_stall_gaps();
        test_reset_mid();
        test_busy_poke();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
